mips_exec_ctrl_unit: RTL and testbench
======================================

MIPS_EXEC_CTRL_UNIT -- requirements
Module: mips_exec_ctrl_unit

Interface
REQ-001 SHALL have parameter: DATA_W, 32, datapath width; only 32 is required to be supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  instr/rs_data/rt_data are valid this cycle.
REQ-005 SHALL have port: instr  input  32  MIPS instruction word; opcode [31:26], funct [5:0], immediate [15:0].
REQ-006 SHALL have port: rs_data  input  32  register-file read port 1, used as ALU operand A.
REQ-007 SHALL have port: rt_data  input  32  register-file read port 2, used as ALU operand B when alu_src=0.
REQ-008 SHALL have port: out_valid  output  1  registered copy of in_valid.
REQ-009 SHALL have port: result  output  32  registered ALU result.
REQ-010 SHALL have port: zero  output  1  registered flag, 1 when the ALU result is 0.
REQ-011 SHALL have port: alu_ctrl  output  4  registered ALU operation code.
REQ-012 SHALL have ports: reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump  output  1 each  registered main-control signals.
REQ-013 SHALL have port: alu_op  output  2  registered main-control ALU class.

Function
REQ-014 Main decode by opcode SHALL be (signals not listed are 0):
- 000000 R-type: reg_dst, reg_write, alu_op=10.
- 100011 lw: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
- 101011 sw: alu_src, mem_write, alu_op=00.
- 000100 beq: branch, alu_op=01.
- 001000 addi: alu_src, reg_write, alu_op=00.
- 000010 j: jump, alu_op=00.
- any other opcode: all signals 0, alu_op=00.
REQ-015 ALU-control decode: alu_op 00 or 11 -> 0010 (add); 01 -> 0110 (sub); 10 -> by funct.
REQ-016 Funct decode (alu_op=10): 100000 -> 0010 add; 100010 -> 0110 sub; 100100 -> 0000 and; 100101 -> 0001 or; 101010 -> 0111 slt; 100111 -> 1100 nor; any other funct -> 0010.
REQ-017 Operand B SHALL be rt_data when alu_src=0, else instr[15:0] sign-extended to 32 bits.
REQ-018 ALU ops: 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 0111 1 if A<B as signed two's complement, else 0; 1100 ~(A|B); any other code -> 0.
REQ-019 Add/sub SHALL wrap modulo 2^32 with no overflow flag or trap.
REQ-020 zero SHALL be 1 exactly when the 32-bit result equals 0, including for undefined ALU codes.
REQ-021 Decode and ALU SHALL be combinational from the inputs, and all outputs SHALL register on the rising clk edge; latency is 1 cycle.
REQ-022 When in_valid=0 the edge SHALL load out_valid=0 and hold all other outputs at their previous values.
REQ-023 Back-to-back in_valid=1 SHALL be accepted every cycle with no stall or backpressure.

Reset
REQ-024 rst=0 SHALL immediately, without a clock edge, force out_valid=0, result=0, zero=0, alu_ctrl=0000, alu_op=00 and all single-bit control outputs to 0.
REQ-025 While rst=0 the outputs SHALL hold their reset values regardless of clk or inputs.
REQ-026 The first edge after rst rises SHALL capture the inputs normally.
REQ-027 Asserting rst mid-stream SHALL discard the in-flight instruction; out_valid stays 0 until a new in_valid=1 is sampled.

Verification
REQ-028 R-type add: instr=0x00221820, rs=5, rt=7 -> next cycle result=12, alu_ctrl=0010, reg_dst=1, reg_write=1, alu_op=10, zero=0.
REQ-029 lw sign-extend: instr=0x8C22FFFC (imm=-4), rs=100 -> result=96, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
REQ-030 beq equal: opcode 000100, rs=rt=0x1234 -> alu_ctrl=0110, result=0, zero=1, branch=1.
REQ-031 slt signed and nor: rs=0xFFFFFFFF, rt=1 with funct 101010 -> result=1; same operands with funct 100111 -> result=0x00000000, zero=1.
REQ-032 Wrap and unknowns: add 0xFFFFFFFF+1 -> result=0, zero=1; opcode 111111 -> all controls 0, alu_ctrl=0010.
REQ-033 Reset: drive valid traffic, pull rst low between edges -> all outputs 0 at once; release -> first out_valid=1 exactly one cycle after the next sampled in_valid=1.

Source files
------------

// File: rtl/mips_exec_ctrl_unit.sv
// mips_exec_ctrl_unit: single-cycle MIPS decode + ALU stage with a registered
// output boundary (latency 1, accepts a new instruction every cycle).
//
// Ports
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   in_valid   - instr / rs_data / rt_data are valid this cycle
//   instr      - instruction word (opcode [31:26], funct [5:0], imm [15:0])
//   rs_data    - ALU operand A
//   rt_data    - ALU operand B when alu_src = 0
//   out_valid  - registered copy of in_valid
//   result     - registered ALU result
//   zero       - registered result == 0 flag
//   alu_ctrl   - registered ALU operation code
//   reg_dst .. jump, alu_op - registered main-control outputs
module mips_exec_ctrl_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [3:0]        alu_ctrl,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic [1:0]        alu_op
);

  localparam int unsigned IMM_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [5:0]        opcode_c;
  logic [5:0]        funct_c;
  ctrl_t             ctrl_c;
  logic [3:0]        alu_ctrl_c;
  logic [DATA_W-1:0] op_b_c;
  logic [DATA_W-1:0] alu_res_c;
  logic              zero_c;

  // rs/rt/rd and shamt fields are consumed by the register file, not here
  logic unused_instr_c;
  assign unused_instr_c = ^instr[25:16];

  assign opcode_c = instr[31:26];
  assign funct_c  = instr[5:0];

  // Main decode by opcode; unknown opcodes leave every control low
  always_comb begin
    ctrl_c = '0;
    unique case (opcode_c)
      OP_RTYPE: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = 2'b10;
      end
      OP_LW: begin
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = 2'b01;
      end
      OP_ADDI: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      OP_J: begin
        ctrl_c.jump = 1'b1;
      end
      default: ctrl_c = '0;
    endcase
  end

  // ALU-control decode; R-type selects by funct, unknown funct falls back to add
  always_comb begin
    alu_ctrl_c = ALU_ADD;
    case (ctrl_c.alu_op)
      2'b01: alu_ctrl_c = ALU_SUB;
      2'b10: begin
        case (funct_c)
          FN_ADD:  alu_ctrl_c = ALU_ADD;
          FN_SUB:  alu_ctrl_c = ALU_SUB;
          FN_AND:  alu_ctrl_c = ALU_AND;
          FN_OR:   alu_ctrl_c = ALU_OR;
          FN_SLT:  alu_ctrl_c = ALU_SLT;
          FN_NOR:  alu_ctrl_c = ALU_NOR;
          default: alu_ctrl_c = ALU_ADD;
        endcase
      end
      default: alu_ctrl_c = ALU_ADD;
    endcase
  end

  // Operand B: register or sign-extended immediate
  assign op_b_c = ctrl_c.alu_src ?
                  {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]} : rt_data;

  // ALU; add/sub wrap naturally at DATA_W bits
  always_comb begin
    alu_res_c = '0;
    case (alu_ctrl_c)
      ALU_AND: alu_res_c = rs_data & op_b_c;
      ALU_OR:  alu_res_c = rs_data | op_b_c;
      ALU_ADD: alu_res_c = rs_data + op_b_c;
      ALU_SUB: alu_res_c = rs_data - op_b_c;
      ALU_SLT: alu_res_c = ($signed(rs_data) < $signed(op_b_c)) ? DATA_W'(1) : '0;
      ALU_NOR: alu_res_c = ~(rs_data | op_b_c);
      default: alu_res_c = '0;
    endcase
  end

  assign zero_c = (alu_res_c == '0);

  // Output register: valid always tracks in_valid, payload only loads on valid
  logic              valid_q,    valid_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic              zero_q,     zero_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  ctrl_t             ctrl_q,     ctrl_d;

  always_comb begin
    valid_d    = in_valid;
    result_d   = result_q;
    zero_d     = zero_q;
    alu_ctrl_d = alu_ctrl_q;
    ctrl_d     = ctrl_q;
    if (in_valid) begin
      result_d   = alu_res_c;
      zero_d     = zero_c;
      alu_ctrl_d = alu_ctrl_c;
      ctrl_d     = ctrl_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      alu_ctrl_q <= 4'b0000;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      alu_ctrl_q <= alu_ctrl_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign out_valid  = valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign reg_dst    = ctrl_q.reg_dst;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_mips_exec_ctrl_unit.sv
// Directed bench for mips_exec_ctrl_unit: hand-computed vectors, one
// instruction per cycle, outputs sampled 1 time unit after the rising edge.
module tb_mips_exec_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  alu_ctrl;
  logic        reg_dst, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, branch, jump;
  logic [1:0]  alu_op;
  logic [9:0]  ctl;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ctl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op}
  localparam logic [9:0] C_R    = 10'b1001000010;
  localparam logic [9:0] C_LW   = 10'b0111100000;
  localparam logic [9:0] C_SW   = 10'b0100010000;
  localparam logic [9:0] C_BEQ  = 10'b0000001001;
  localparam logic [9:0] C_ADDI = 10'b0101000000;
  localparam logic [9:0] C_J    = 10'b0000000100;
  localparam logic [9:0] C_NONE = 10'b0000000000;

  assign ctl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
                mem_write, branch, jump, alu_op};

  always #5 clk = ~clk;

  mips_exec_ctrl_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
    .result(result), .zero(zero), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_op(alu_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] res,
                            input logic z, input logic [3:0] ac, input logic [9:0] c);
    chk({tag, ".valid"},    32'(out_valid), 32'(v));
    chk({tag, ".result"},   result,         res);
    chk({tag, ".zero"},     32'(zero),      32'(z));
    chk({tag, ".alu_ctrl"}, 32'(alu_ctrl),  32'(ac));
    chk({tag, ".ctl"},      32'(ctl),       32'(c));
  endtask

  // Drive one cycle of inputs at the falling edge, sample after the next rising edge
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = v;
    instr    = ins;
    rs_data  = a;
    rt_data  = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    instr    = 32'h0;
    rs_data  = 32'h0;
    rt_data  = 32'h0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1 expect_out("reset", 1'b0, 32'h0, 1'b0, 4'b0000, C_NONE);
    @(negedge clk);
    rst = 1'b1;

    // Main decode + ALU, back-to-back valid instructions
    step(1'b1, 32'h00221820, 32'd5, 32'd7);
    expect_out("radd", 1'b1, 32'd12, 1'b0, 4'b0010, C_R);
    step(1'b1, 32'h8C22FFFC, 32'd100, 32'd55);
    expect_out("lw", 1'b1, 32'd96, 1'b0, 4'b0010, C_LW);
    step(1'b1, 32'hAC220008, 32'h10, 32'h99);
    expect_out("sw", 1'b1, 32'h18, 1'b0, 4'b0010, C_SW);
    step(1'b1, 32'h10221234, 32'h1234, 32'h1234);
    expect_out("beq", 1'b1, 32'h0, 1'b1, 4'b0110, C_BEQ);
    step(1'b1, 32'h0022182A, 32'hFFFFFFFF, 32'd1);
    expect_out("slt", 1'b1, 32'd1, 1'b0, 4'b0111, C_R);
    step(1'b1, 32'h00221827, 32'hFFFFFFFF, 32'd1);
    expect_out("nor", 1'b1, 32'h0, 1'b1, 4'b1100, C_R);
    step(1'b1, 32'h00221820, 32'hFFFFFFFF, 32'd1);
    expect_out("wrap", 1'b1, 32'h0, 1'b1, 4'b0010, C_R);
    step(1'b1, 32'hFC000000, 32'd3, 32'd4);
    expect_out("badop", 1'b1, 32'd7, 1'b0, 4'b0010, C_NONE);
    step(1'b1, 32'h2022FFFF, 32'd10, 32'd77);
    expect_out("addi", 1'b1, 32'd9, 1'b0, 4'b0010, C_ADDI);
    step(1'b1, 32'h08000010, 32'd1, 32'd2);
    expect_out("j", 1'b1, 32'd3, 1'b0, 4'b0010, C_J);
    step(1'b1, 32'h00221822, 32'd5, 32'd7);
    expect_out("sub", 1'b1, 32'hFFFFFFFE, 1'b0, 4'b0110, C_R);
    step(1'b1, 32'h00221824, 32'h0000F0F0, 32'h0000FF00);
    expect_out("and", 1'b1, 32'h0000F000, 1'b0, 4'b0000, C_R);
    step(1'b1, 32'h00221825, 32'h0000F0F0, 32'h0000FF00);
    expect_out("or", 1'b1, 32'h0000FFF0, 1'b0, 4'b0001, C_R);
    step(1'b1, 32'h00221821, 32'd5, 32'd7);
    expect_out("badfn", 1'b1, 32'd12, 1'b0, 4'b0010, C_R);

    // in_valid=0: out_valid drops, payload holds the previous instruction
    step(1'b0, 32'h10221234, 32'h5, 32'h5);
    expect_out("hold", 1'b0, 32'd12, 1'b0, 4'b0010, C_R);
    step(1'b0, 32'h8C22FFFC, 32'h0, 32'h0);
    expect_out("hold2", 1'b0, 32'd12, 1'b0, 4'b0010, C_R);

    // Mid-stream reset between edges clears everything at once
    step(1'b1, 32'h8C22FFFC, 32'd100, 32'd0);
    expect_out("pre_rst", 1'b1, 32'd96, 1'b0, 4'b0010, C_LW);
    #2 rst = 1'b0;
    #1 expect_out("mid_rst", 1'b0, 32'h0, 1'b0, 4'b0000, C_NONE);
    step(1'b1, 32'h00221820, 32'd5, 32'd7);
    expect_out("rst_held", 1'b0, 32'h0, 1'b0, 4'b0000, C_NONE);

    // Release with no valid input: stays idle until valid is sampled
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 expect_out("post_rst_idle", 1'b0, 32'h0, 1'b0, 4'b0000, C_NONE);
    step(1'b1, 32'h00221820, 32'd20, 32'd22);
    expect_out("post_rst_first", 1'b1, 32'd42, 1'b0, 4'b0010, C_R);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
